// File: rtl/etx_frame_serializer.sv
// etx_frame_serializer: pops 64-bit TX FIFO words and emits framed bytes
// (optional length header, payload, zero pad) followed by an idle gap.
module etx_frame_serializer #(
  parameter bit HDR_EN      = 1'b1,
  parameter int MIN_PAYLOAD = 46,
  parameter int GAP_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        etx_enable,
  input  logic        etx_empty,
  input  logic [63:0] etx_dout,
  output logic        etx_rd_en,
  input  logic [15:0] tx_data_length,
  input  logic [15:0] tx_total_length,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eof,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_PAD  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [15:0] MINP  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] GAPM1 = 16'(GAP_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] dl_q, dl_d;
  logic [15:0] tl_q, tl_d;
  logic [15:0] padn_q, padn_d;
  logic [13:0] wn_q, wn_d;
  logic [13:0] pops_q, pops_d;
  logic [15:0] gcnt_q, gcnt_d;
  logic [63:0] cur_q, cur_d;
  logic        cur_v_q, cur_v_d;
  logic [63:0] nxt_q, nxt_d;
  logic        nxt_v_q, nxt_v_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_sof_q, m_sof_d;
  logic        m_eof_q, m_eof_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [15:0] pl_max;
  logic [1:0]  occ;
  logic [7:0]  byte_sel;
  logic        start, can_load, hs_eof, last, consume;

  assign occ = {1'b0, cur_v_q} + {1'b0, nxt_v_q} + {1'b0, rd_pend_q};
  assign byte_sel = cur_q[{~cnt_q[2:0], 3'b000} +: 8];
  assign last = (cnt_q == dl_q - 16'd1);
  assign start = etx_enable && !etx_empty && (tx_data_length != 16'd0);
  // Output slot free, and never overwrite a pending eof byte.
  assign can_load = !m_valid_q || (m_ready && !m_eof_q);
  assign hs_eof = m_valid_q && m_ready && m_eof_q;

  // At most one word ahead of the one being serialized.
  assign etx_rd_en = ((state_q == S_HDR) || (state_q == S_PAY)) &&
                     !etx_empty && (pops_q < wn_q) && (occ < 2'd2);

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_sof     = m_sof_q;
  assign m_eof     = m_eof_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dl_d        = dl_q;
    tl_d        = tl_q;
    padn_d      = padn_q;
    wn_d        = wn_q;
    pops_d      = pops_q + {13'd0, etx_rd_en};
    gcnt_d      = gcnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_sof_d     = m_sof_q;
    m_eof_d     = m_eof_q;
    frame_cnt_d = frame_cnt_q;
    consume     = 1'b0;
    pl_max      = tx_data_length;
    if (tx_total_length > pl_max) pl_max = tx_total_length;
    if (MINP > pl_max) pl_max = MINP;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_sof_d   = 1'b0;
      m_eof_d   = 1'b0;
    end
    case (state_q)
      S_IDLE, S_GAP: begin
        if ((state_q == S_GAP) && (gcnt_q != 16'd0)) begin
          gcnt_d = gcnt_q - 16'd1;
        end else if (start) begin
          dl_d   = tx_data_length;
          tl_d   = tx_total_length;
          padn_d = pl_max - tx_data_length;
          wn_d   = {1'b0, tx_data_length[15:3]} +
                   {13'd0, |tx_data_length[2:0]};
          pops_d = '0;
          if (HDR_EN) begin
            state_d   = S_HDR;
            cnt_d     = 16'd1;
            m_valid_d = 1'b1;
            m_sof_d   = 1'b1;
            m_eof_d   = 1'b0;
            m_data_d  = tx_total_length[15:8];
          end else begin
            state_d = S_PAY;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (can_load) begin
          m_valid_d = 1'b1;
          m_sof_d   = 1'b0;
          m_eof_d   = 1'b0;
          case (cnt_q[1:0])
            2'd1:    m_data_d = tl_q[7:0];
            2'd2:    m_data_d = dl_q[15:8];
            default: m_data_d = dl_q[7:0];
          endcase
          if (cnt_q[1:0] == 2'd3) begin
            state_d = S_PAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_PAY: begin
        if (can_load && cur_v_q) begin
          m_valid_d = 1'b1;
          m_sof_d   = (HDR_EN == 1'b0) && (cnt_q == 16'd0);
          m_eof_d   = last && (padn_q == 16'd0);
          m_data_d  = byte_sel;
          consume   = last || (cnt_q[2:0] == 3'd7);
          if (last) begin
            cnt_d = '0;
            if (padn_q != 16'd0) state_d = S_PAD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_PAD: begin
        if (can_load) begin
          m_valid_d = 1'b1;
          m_sof_d   = 1'b0;
          m_eof_d   = (cnt_q == padn_q - 16'd1);
          m_data_d  = '0;
          cnt_d     = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (hs_eof) begin
      state_d     = S_GAP;
      gcnt_d      = GAPM1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Word buffer: the FIFO word lands one clock after the pop.
  always_comb begin
    cur_d     = cur_q;
    cur_v_d   = cur_v_q;
    nxt_d     = nxt_q;
    nxt_v_d   = nxt_v_q;
    rd_pend_d = etx_rd_en;
    if (consume) begin
      cur_d   = nxt_q;
      cur_v_d = nxt_v_q;
      nxt_v_d = 1'b0;
    end
    if (rd_pend_q) begin
      if (!cur_v_d) begin
        cur_d   = etx_dout;
        cur_v_d = 1'b1;
      end else begin
        nxt_d   = etx_dout;
        nxt_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dl_q        <= '0;
      tl_q        <= '0;
      padn_q      <= '0;
      wn_q        <= '0;
      pops_q      <= '0;
      gcnt_q      <= '0;
      cur_q       <= '0;
      cur_v_q     <= 1'b0;
      nxt_q       <= '0;
      nxt_v_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_sof_q     <= 1'b0;
      m_eof_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dl_q        <= dl_d;
      tl_q        <= tl_d;
      padn_q      <= padn_d;
      wn_q        <= wn_d;
      pops_q      <= pops_d;
      gcnt_q      <= gcnt_d;
      cur_q       <= cur_d;
      cur_v_q     <= cur_v_d;
      nxt_q       <= nxt_d;
      nxt_v_q     <= nxt_v_d;
      rd_pend_q   <= rd_pend_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_sof_q     <= m_sof_d;
      m_eof_q     <= m_eof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_etx_frame_serializer.sv
// Bench for etx_frame_serializer: FIFO model, byte-stream reference model
// and a per-cycle compare process on the MAC side.
module tb_etx_frame_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        etx_enable = 1'b0;
  logic        etx_empty;
  logic [63:0] etx_dout = '0;
  logic        etx_rd_en;
  logic [15:0] tx_data_length = '0;
  logic [15:0] tx_total_length = '0;
  logic [7:0]  m_data;
  logic        m_valid, m_sof, m_eof;
  logic        m_ready = 1'b1;
  logic        busy;
  logic [15:0] frame_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int ready_mode = 0;

  etx_frame_serializer dut (
    .clk(clk), .rst(rst), .etx_enable(etx_enable), .etx_empty(etx_empty),
    .etx_dout(etx_dout), .etx_rd_en(etx_rd_en),
    .tx_data_length(tx_data_length), .tx_total_length(tx_total_length),
    .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eof(m_eof),
    .m_ready(m_ready), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Standard FIFO model: data appears on etx_dout one clock after pop.
  logic [63:0] mem [0:255];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign etx_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (etx_rd_en && (rd_ptr != wr_ptr)) begin
      etx_dout <= mem[rd_ptr[7:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) m_ready = ~m_ready;
    else m_ready = 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference stream: {sof, eof, byte}
  logic [9:0] exp_q[$];

  task automatic expect_frame(input int dl, input int tl, input int ptr);
    int pl, nb, k;
    logic [63:0] w;
    logic [7:0] b;
    logic [15:0] dlv, tlv;
    dlv = 16'(dl);
    tlv = 16'(tl);
    pl = dl;
    if (tl > pl) pl = tl;
    if (46 > pl) pl = 46;
    nb = 4 + pl;
    for (int i = 0; i < nb; i++) begin
      if (i == 0) b = tlv[15:8];
      else if (i == 1) b = tlv[7:0];
      else if (i == 2) b = dlv[15:8];
      else if (i == 3) b = dlv[7:0];
      else if (i - 4 < dl) begin
        k = i - 4;
        w = mem[8'(ptr + k / 8)];
        b = w[63 - 8 * (k % 8) -: 8];
      end else b = 8'h00;
      exp_q.push_back({i == 0, i == nb - 1, b});
    end
  endtask

  logic       prev_stall = 1'b0;
  logic [9:0] prev_got = '0;
  bit         in_frame = 1'b0;
  bit         gap_trk = 1'b0;
  int         span = 0;
  int         last_span = 0;
  int         idle = 0;
  int         last_gap = -1;

  always @(negedge clk) begin : cmp
    logic [9:0] got;
    logic [9:0] e;
    got = {m_sof, m_eof, m_data};
    if (rst) begin
      prev_stall = 1'b0;
      in_frame = 1'b0;
      gap_trk = 1'b0;
    end else begin
      if (etx_rd_en) check("rd_en_while_empty", 32'(etx_empty), 32'd0);
      if (prev_stall)
        check("stall_hold", 32'({m_valid, got}), 32'({1'b1, prev_got}));
      if (gap_trk) begin
        if (m_valid) begin
          last_gap = idle;
          gap_trk = 1'b0;
        end else idle++;
      end
      if (m_valid && m_sof && !in_frame) begin
        in_frame = 1'b1;
        span = 0;
      end
      if (in_frame) span++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte got=%0h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          check("stream_byte", 32'(got), 32'(e));
        end
        if (m_eof) begin
          in_frame = 1'b0;
          last_span = span;
          gap_trk = 1'b1;
          idle = 0;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_got = got;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input logic [15:0] target);
    int t;
    t = 0;
    while ((frame_cnt != target) && (t < 3000)) begin
      @(negedge clk);
      t++;
    end
    check("frame_cnt", 32'(frame_cnt), 32'(target));
  endtask

  initial begin
    @(negedge clk);
    check("rst_ctrl", 32'({etx_rd_en, m_valid, m_sof, m_eof, busy}), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Frame 1: DL=16, TL=0, enable dropped mid-frame, lengths changed
    mem[0] = 64'h0102030405060708;
    mem[1] = 64'h1112131415161718;
    mem[2] = 64'h2122232425262728;
    wr_ptr = 3;
    expect_frame(16, 0, 0);
    check("model1_len", 32'(exp_q.size()), 32'd50);
    check("model1_b0", 32'(exp_q[0]), 32'h200);
    check("model1_b3", 32'(exp_q[3]), 32'h010);
    check("model1_b4", 32'(exp_q[4]), 32'h001);
    check("model1_eof", 32'(exp_q[49]), 32'h100);
    tx_data_length = 16'd16;
    tx_total_length = 16'd0;
    etx_enable = 1'b1;
    cyc(3);
    etx_enable = 1'b0;
    tx_data_length = 16'd99;
    tx_total_length = 16'd7;
    wait_cnt(16'd1);
    check("f1_pops", 32'(rd_ptr), 32'd2);
    check("f1_span", 32'(last_span), 32'd50);
    check("f1_drained", 32'(exp_q.size()), 32'd0);
    cyc(30);
    check("f1_no_restart", 32'({busy, m_valid}), 32'd0);
    check("f1_left_word", 32'(rd_ptr), 32'd2);

    // Frame 2: DL=13, TL=64
    mem[3] = 64'hA1A2A3A4A5A6A7A8;
    wr_ptr = 4;
    expect_frame(13, 64, 2);
    check("model2_len", 32'(exp_q.size()), 32'd68);
    check("model2_b4", 32'(exp_q[4]), 32'h021);
    check("model2_b16", 32'(exp_q[16]), 32'h0A5);
    check("model2_b17", 32'(exp_q[17]), 32'h000);
    check("model2_eof", 32'(exp_q[67]), 32'h100);
    tx_data_length = 16'd13;
    tx_total_length = 16'd64;
    etx_enable = 1'b1;
    wait_cnt(16'd2);
    check("f2_pops", 32'(rd_ptr), 32'd4);
    check("f2_span", 32'(last_span), 32'd68);
    check("f2_drained", 32'(exp_q.size()), 32'd0);
    cyc(20);

    // Frame 3: m_ready toggling
    for (int i = 4; i < 7; i++) mem[i] = {$urandom, $urandom};
    tx_data_length = 16'd20;
    tx_total_length = 16'd0;
    expect_frame(20, 0, 4);
    ready_mode = 1;
    wr_ptr = 7;
    wait_cnt(16'd3);
    ready_mode = 0;
    check("f3_pops", 32'(rd_ptr), 32'd7);
    check("f3_drained", 32'(exp_q.size()), 32'd0);
    cyc(20);

    // Frame 4: FIFO runs dry after the first word
    for (int i = 7; i < 10; i++) mem[i] = {$urandom, $urandom};
    tx_data_length = 16'd24;
    tx_total_length = 16'd50;
    expect_frame(24, 50, 7);
    wr_ptr = 8;
    cyc(16);
    check("f4_stall_valid", 32'({busy, m_valid}), 32'b10);
    check("f4_stall_pops", 32'(rd_ptr), 32'd8);
    cyc(5);
    wr_ptr = 10;
    wait_cnt(16'd4);
    check("f4_pops", 32'(rd_ptr), 32'd10);
    check("f4_drained", 32'(exp_q.size()), 32'd0);
    cyc(20);

    // Frames 5+6 back to back
    for (int i = 10; i < 12; i++) mem[i] = {$urandom, $urandom};
    tx_data_length = 16'd8;
    tx_total_length = 16'd0;
    expect_frame(8, 0, 10);
    expect_frame(8, 0, 11);
    wr_ptr = 12;
    wait_cnt(16'd6);
    check("b2b_gap", 32'(last_gap), 32'd12);
    check("b2b_pops", 32'(rd_ptr), 32'd12);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    cyc(20);

    // Async reset mid-payload
    for (int i = 12; i < 17; i++) mem[i] = {$urandom, $urandom};
    tx_data_length = 16'd40;
    tx_total_length = 16'd0;
    expect_frame(40, 0, 12);
    wr_ptr = 17;
    cyc(12);
    check("pre_rst_busy", 32'({busy, m_valid}), 32'b11);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ctrl", 32'({etx_rd_en, m_valid, m_sof, m_eof, busy}), 32'd0);
    check("arst_data", 32'(m_data), 32'd0);
    check("arst_cnt", 32'(frame_cnt), 32'd0);
    etx_enable = 1'b0;
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'({busy, m_valid, etx_rd_en}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
